// File: rtl/gamma_lut_ctrl_pkg.sv
// Shared definitions for the gamma LUT controller:
// - default widths
// - controller state encoding
// - the gamma 1.0 identity expansion used by both the init fill and the bypass path
package gamma_lut_ctrl_pkg;

    localparam int DW_IN_DEF  = 8;
    localparam int DW_OUT_DEF = 12;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_PEND
    } state_e;

    // Replicate the top input bits into the extra output LSBs so that full
    // scale in maps to full scale out (0xFF -> 0xFFF).
    function automatic logic [DW_OUT_DEF-1:0] identityExpand(input logic [DW_IN_DEF-1:0] d);
        return {d, d[DW_IN_DEF-1 -: (DW_OUT_DEF - DW_IN_DEF)]};
    endfunction

endpackage

// File: rtl/gamma_lut_ram.sv
// Simple dual-port LUT storage holding both banks (bank select is the address MSB).
// - one write port
// - one clock-enabled synchronous read port
// No reset on the array or the read register, so it maps onto a single block RAM.
module gamma_lut_ram #(
    parameter int AW = 9,
    parameter int DW = 12
) (
    input  logic          clk_i,
    input  logic          ce_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i
);

    logic [DW-1:0] mem [0:(2**AW)-1];
    logic [DW-1:0] rdata_q;

    // Write port: one entry per cycle when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Read port: registered read that advances only on pixel clock enable.
    always_ff @(posedge clk_i) begin
        if (ce_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/gamma_lut_ctrl.sv
// Double-banked programmable gamma LUT controller.
//
// Bank roles:
// - The active bank feeds the pixel stream.
// - The host writes only the shadow bank.
//
// Bank swap:
// - A COMMIT arms a swap.
// - The swap then happens on the next VSYNC rising edge, so a frame never
//   mixes two tables.
//
// Initialisation:
// - After reset both banks are filled with the identity curve.
// - Host traffic is ignored until that fill is finished.
module gamma_lut_ctrl
    import gamma_lut_ctrl_pkg::*;
#(
    parameter int DW_IN  = DW_IN_DEF,
    parameter int DW_OUT = DW_OUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ce_i,
    input  logic              en_i,
    input  logic              vsync_i,
    input  logic [DW_IN-1:0]  din_i,
    output logic [DW_OUT-1:0] dout_o,
    input  logic              wr_req_i,
    input  logic [DW_IN-1:0]  wr_addr_i,
    input  logic [DW_OUT-1:0] wr_data_i,
    output logic              wr_ack_o,
    input  logic              commit_i,
    output logic              swap_pend_o,
    output logic              swap_done_o,
    output logic              act_bank_o,
    output logic              init_done_o
);

    localparam int            AW       = DW_IN + 1;
    localparam logic [AW-1:0] CNT_LAST = '1;

    state_e              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic                act_bank_q, act_bank_d;
    logic                init_done_q, init_done_d;
    logic                wr_ack_q, wr_ack_d;
    logic                swap_done_q, swap_done_d;
    logic                vsync_q;

    logic                ram_we;
    logic [AW-1:0]       ram_waddr;
    logic [DW_OUT-1:0]   ram_wdata;
    logic [DW_OUT-1:0]   ram_rdata;

    logic                sel_lut_q;
    logic [DW_OUT-1:0]   bypass_q;

    logic                vsync_rise;
    logic                wr_accept;

    // A write is taken only in IDLE and never in the cycle that acknowledges
    // the previous one, so a held request cannot be committed twice.
    assign vsync_rise = vsync_i & ~vsync_q;
    assign wr_accept  = (state_q == ST_IDLE) & wr_req_i & ~wr_ack_q;

    // State register and all controller flags; everything returns to the init state on reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            act_bank_q  <= 1'b0;
            init_done_q <= 1'b0;
            wr_ack_q    <= 1'b0;
            swap_done_q <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_bank_q  <= act_bank_d;
            init_done_q <= init_done_d;
            wr_ack_q    <= wr_ack_d;
            swap_done_q <= swap_done_d;
            vsync_q     <= vsync_i;
        end
    end

    // Next-state logic and RAM write port steering (init fill vs host write).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_bank_d  = act_bank_q;
        init_done_d = init_done_q;
        wr_ack_d    = 1'b0;
        swap_done_d = 1'b0;
        ram_we      = 1'b0;
        ram_waddr   = {~act_bank_q, wr_addr_i};
        ram_wdata   = wr_data_i;

        case (state_q)
            ST_INIT: begin
                ram_we    = 1'b1;
                ram_waddr = cnt_q;
                ram_wdata = identityExpand(cnt_q[DW_IN-1:0]);
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d     = ST_IDLE;
                    init_done_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (wr_accept) begin
                    ram_we   = 1'b1;
                    wr_ack_d = 1'b1;
                end
                if (commit_i) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (vsync_rise) begin
                    act_bank_d  = ~act_bank_q;
                    swap_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Video path registers.
    // The LUT-or-bypass choice is captured alongside the RAM read so both
    // sources line up after one enabled cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel_lut_q <= 1'b0;
            bypass_q  <= '0;
        end else if (ce_i) begin
            sel_lut_q <= en_i & init_done_q;
            bypass_q  <= identityExpand(din_i);
        end
    end

    gamma_lut_ram #(
        .AW (AW),
        .DW (DW_OUT)
    ) u_ram (
        .clk_i   (clk_i),
        .ce_i    (ce_i),
        .raddr_i ({act_bank_q, din_i}),
        .rdata_o (ram_rdata),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata)
    );

    assign dout_o      = sel_lut_q ? ram_rdata : bypass_q;
    assign wr_ack_o    = wr_ack_q;
    assign swap_pend_o = (state_q == ST_PEND);
    assign swap_done_o = swap_done_q;
    assign act_bank_o  = act_bank_q;
    assign init_done_o = init_done_q;

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Directed bench for gamma_lut_ctrl.
// - Table vectors cover the video path.
// - Hand-written sequences cover init, host writes, bank swaps and reset.
module tb_gamma_lut_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce, en, vsync;
    logic [7:0]  din;
    logic [11:0] dout;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [11:0] wr_data;
    logic        wr_ack;
    logic        commit;
    logic        swap_pend, swap_done, act_bank, init_done;

    int nVec  = 0;
    int nFail = 0;

    typedef struct {
        logic        en;
        logic        ce;
        logic [7:0]  din;
        logic [11:0] exp;
        string       name;
    } vec_t;

    vec_t vecQ[$];

    always #5 clk = ~clk;

    gamma_lut_ctrl dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .ce_i        (ce),
        .en_i        (en),
        .vsync_i     (vsync),
        .din_i       (din),
        .dout_o      (dout),
        .wr_req_i    (wr_req),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_ack_o    (wr_ack),
        .commit_i    (commit),
        .swap_pend_o (swap_pend),
        .swap_done_o (swap_done),
        .act_bank_o  (act_bank),
        .init_done_o (init_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [11:0] actual, input logic [11:0] expected);
        nVec++;
        if (actual !== expected) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%03h, expected 0x%03h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic e, input logic c, input logic [7:0] d, input logic [11:0] x, input string n);
        vec_t v;
        v.en = e; v.ce = c; v.din = d; v.exp = x; v.name = n;
        vecQ.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        en  = v.en;
        ce  = v.ce;
        din = v.din;
        tick();
    endtask

    task automatic runTable(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            applyStimulus(vecQ[i]);
            checkOutput(vecQ[i].name, dout, vecQ[i].exp);
        end
    endtask

    task automatic writeEntry(input logic [7:0] a, input logic [11:0] d, input string n);
        logic got;
        got     = 1'b0;
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        for (int k = 0; k < 8 && !got; k++) begin
            tick();
            if (wr_ack) got = 1'b1;
        end
        wr_req = 1'b0;
        checkOutput(n, {11'b0, got}, 12'h001);
    endtask

    task automatic checkResetOutputs(input string n);
        checkOutput({n, "_dout"}, dout, 12'h000);
        checkOutput({n, "_flags"}, {7'b0, wr_ack, swap_pend, swap_done, act_bank, init_done}, 12'h000);
    endtask

    // Counts init edges from reset release with DIN held.
    // Checks INIT_DONE is still low just before the last fill write and high right after it.
    task automatic runInit(input string n);
        for (int i = 1; i <= 512; i++) begin
            tick();
            if (i == 511) checkOutput({n, "_init_done_511"}, {11'b0, init_done}, 12'h000);
            if (i == 512) checkOutput({n, "_init_done_512"}, {11'b0, init_done}, 12'h001);
        end
    endtask

    // Pulses COMMIT for one cycle, then forces a VSYNC rise to complete the swap.
    task automatic doSwap();
        vsync  = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        vsync  = 1'b1;
        tick();
        vsync  = 1'b0;
    endtask

    initial begin
        logic ackSeen;
        rst_n = 1'b0; ce = 1'b0; en = 1'b0; vsync = 1'b0; din = '0;
        wr_req = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;

        // Video-path vectors: first block against the identity bank, second after the custom swap.
        addVec(1, 1, 8'h80, 12'h808, "pre_lut_80");
        addVec(1, 1, 8'h00, 12'h000, "pre_lut_00");
        addVec(0, 1, 8'hA5, 12'hA5A, "pre_bypass_a5");
        addVec(1, 0, 8'h3C, 12'hA5A, "pre_ce_hold");
        addVec(1, 1, 8'h80, 12'hABC, "post_lut_80");
        addVec(1, 1, 8'h00, 12'h123, "post_lut_00");
        addVec(1, 1, 8'hFF, 12'h000, "post_lut_ff");
        addVec(1, 1, 8'h3C, 12'h777, "post_lut_3c");
        addVec(1, 0, 8'h80, 12'h777, "post_ce_hold");
        addVec(0, 1, 8'h80, 12'h808, "post_bypass_80");
        addVec(0, 1, 8'hFF, 12'hFFF, "post_bypass_ff");
        addVec(0, 0, 8'h00, 12'hFFF, "post_bypass_hold");
        addVec(1, 1, 8'h11, 12'h111, "post_lut_untouched");
        addVec(1, 1, 8'h80, 12'hABC, "post_lut_80_again");

        // Reset values and the init fill.
        // COMMIT, WR_REQ and VSYNC are toggled mid-fill and must be ignored.
        $display("[TB] reset and init fill");
        #12;
        checkResetOutputs("reset");
        en = 1'b1; ce = 1'b1; din = 8'h10;
        @(negedge clk);
        rst_n   = 1'b1;
        ackSeen = 1'b0;
        for (int i = 1; i <= 512; i++) begin
            commit = (i == 10);
            vsync  = (i >= 20 && i < 30);
            wr_req = (i >= 40 && i < 46);
            tick();
            if (wr_ack) ackSeen = 1'b1;
            if (i == 11)  checkOutput("init_commit_ignored", {11'b0, swap_pend}, 12'h000);
            if (i == 511) checkOutput("init_done_511", {11'b0, init_done}, 12'h000);
            if (i == 512) checkOutput("init_done_512", {11'b0, init_done}, 12'h001);
        end
        commit = 1'b0; vsync = 1'b0; wr_req = 1'b0;
        checkOutput("init_wr_ignored", {11'b0, ackSeen}, 12'h000);
        checkOutput("init_no_swap", {10'b0, swap_done, act_bank}, 12'h000);
        tick();
        checkOutput("init_first_lut_pixel", dout, 12'h101);

        // Load the shadow bank.
        // The active bank must still read identity until the swap.
        $display("[TB] shadow writes and swap");
        writeEntry(8'h80, 12'hABC, "wr_ack_80");
        writeEntry(8'h00, 12'h123, "wr_ack_00");
        writeEntry(8'hFF, 12'h000, "wr_ack_ff");
        writeEntry(8'h3C, 12'h777, "wr_ack_3c");
        tick();
        checkOutput("wr_ack_single_pulse", {11'b0, wr_ack}, 12'h000);
        runTable(0, 3);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        checkOutput("commit_pend", {10'b0, swap_pend, act_bank}, 12'h002);
        tick();
        tick();
        checkOutput("pend_wait", {10'b0, swap_pend, swap_done}, 12'h002);
        en = 1'b1; ce = 1'b1; din = 8'h80; vsync = 1'b1;
        tick();
        checkOutput("swap_flags", {9'b0, swap_done, act_bank, swap_pend}, 12'h006);
        checkOutput("swap_cycle_old_bank", dout, 12'h808);
        tick();
        checkOutput("swap_done_pulse", {11'b0, swap_done}, 12'h000);
        checkOutput("first_new_bank_pixel", dout, 12'hABC);
        runTable(4, 13);
        vsync = 1'b0;
        tick();

        // A write requested while a swap is pending stalls until the swap.
        // It then lands in the new shadow bank.
        $display("[TB] write stalled during pending swap");
        commit = 1'b1;
        tick();
        commit = 1'b0;
        wr_req = 1'b1; wr_addr = 8'h22; wr_data = 12'h5A5;
        ackSeen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (wr_ack) ackSeen = 1'b1;
        end
        checkOutput("pend_write_stalled", {11'b0, ackSeen}, 12'h000);
        vsync = 1'b1;
        tick();
        checkOutput("pend_swap_no_ack", {9'b0, swap_done, wr_ack, act_bank}, 12'h004);
        tick();
        checkOutput("pend_write_ack", {11'b0, wr_ack}, 12'h001);
        wr_req = 1'b0;
        tick();
        checkOutput("pend_write_ack_drop", {11'b0, wr_ack}, 12'h000);
        en = 1'b1; ce = 1'b1; din = 8'h22;
        tick();
        checkOutput("pend_write_not_active", dout, 12'h222);
        doSwap();
        checkOutput("pend_write_reswap_bank", {11'b0, act_bank}, 12'h001);
        tick();
        checkOutput("pend_write_visible", dout, 12'h5A5);

        // VSYNC rise in IDLE does nothing.
        // COMMIT with WR_REQ in the same cycle is both written and armed.
        $display("[TB] commit with write, idle vsync");
        vsync = 1'b1;
        tick();
        checkOutput("idle_vsync_ignored", {10'b0, swap_done, act_bank}, 12'h001);
        commit = 1'b1; wr_req = 1'b1; wr_addr = 8'h40; wr_data = 12'h0F0;
        tick();
        commit = 1'b0; wr_req = 1'b0;
        checkOutput("commit_write_ack", {10'b0, wr_ack, swap_pend}, 12'h003);
        tick();
        tick();
        checkOutput("held_vsync_no_swap", {10'b0, swap_pend, act_bank}, 12'h003);
        vsync = 1'b0;
        tick();
        vsync = 1'b1;
        din = 8'h40;
        tick();
        checkOutput("next_rise_swap", {10'b0, swap_done, act_bank}, 12'h002);
        tick();
        checkOutput("commit_write_visible", dout, 12'h0F0);
        vsync = 1'b0;

        // Reset during a pending swap and again mid-init.
        // Each reset returns every output to its reset value and restarts the fill.
        $display("[TB] reset during pend and mid-init");
        tick();
        doSwap();
        checkOutput("pre_reset_bank", {11'b0, act_bank}, 12'h001);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        checkOutput("pre_reset_pend", {11'b0, swap_pend}, 12'h001);
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("reset_pend");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        checkOutput("mid_init_not_done", {11'b0, init_done}, 12'h000);
        #2 rst_n = 1'b0;
        #1;
        checkResetOutputs("reset_init");
        en = 1'b1; ce = 1'b1; din = 8'h40;
        @(negedge clk);
        rst_n = 1'b1;
        runInit("reinit");
        tick();
        checkOutput("reinit_identity_40", dout, 12'h404);
        checkOutput("reinit_bank0", {11'b0, act_bank}, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
